// File: rtl/weight_update_engine.sv
// weight_update_engine: serially applies a buffered delta vector to a saturating weight bank
module weight_update_engine #(
  parameter int N = 4,
  parameter int W = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             delta_valid,
  output logic             delta_ready,
  input  logic [N*W-1:0]   delta_w_in,
  input  logic             load_init,
  input  logic [N*W-1:0]   w_init,
  output logic [N*W-1:0]   w_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] update_count
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [N*W-1:0] w_q, dbuf;
  logic last;
  function automatic logic [W-1:0] sat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    return (s[W] != s[W-1]) ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
  endfunction
  assign last = (idx == IW'(N - 1));
  assign delta_ready = (state == IDLE) && !load_init && !RST;
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign w_out = w_q;
  // state register
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= state_n;
  // next state: load_init blocks acceptance, APPLY ends on the last element, DONE lasts one cycle
  always_comb begin
    state_n = state;
    if (state == IDLE && !load_init && delta_valid) state_n = APPLY;
    else if (state == APPLY && last) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  // weight bank, delta buffer, element index and completion counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_q <= '0;
      dbuf <= '0;
      idx <= '0;
      update_count <= '0;
    end else begin
      if (state == IDLE && load_init) w_q <= w_init;
      if (state == IDLE && !load_init && delta_valid) begin
        dbuf <= delta_w_in;
        idx <= '0;
      end
      if (state == APPLY) begin
        w_q[idx*W +: W] <= sat(w_q[idx*W +: W], dbuf[idx*W +: W]);
        idx <= last ? idx : idx + IW'(1);
      end
      if (state == DONE) update_count <= update_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_weight_update_engine.sv
// tb_weight_update_engine: directed vector table plus hand sequences for latency, backpressure, priority, reset and wrap
module tb_weight_update_engine;
  localparam int N = 4;
  localparam int W = 32;
  localparam logic [31:0] MX = 32'h7fffffff;
  localparam logic [31:0] MN = 32'h80000000;
  logic CLK = 0;
  logic RST = 1;
  logic delta_valid = 0, load_init = 0, delta_ready, busy, done;
  logic [N*W-1:0] delta_w_in = '0, w_init = '0, w_out;
  logic [15:0] update_count;
  logic valid2 = 0, load2 = 0, ready2, busy2, done2;
  logic [N*W-1:0] delta2 = '0, w_out2;
  logic [1:0] count2;
  int pass_cnt = 0, total = 0, cnt_exp = 0;
  typedef struct {
    logic [N*W-1:0] init;
    logic [N*W-1:0] delta;
    logic [N*W-1:0] exp;
  } vec_t;
  vec_t vecs [5];
  logic [N*W-1:0] mid [N];
  logic [1:0] wrap_exp [5];
  bit seen;

  always #5 CLK = ~CLK;

  weight_update_engine #(.N(N), .W(W), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .delta_valid(delta_valid), .delta_ready(delta_ready),
    .delta_w_in(delta_w_in), .load_init(load_init), .w_init(w_init), .w_out(w_out),
    .busy(busy), .done(done), .update_count(update_count));

  weight_update_engine #(.N(N), .W(W), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .delta_valid(valid2), .delta_ready(ready2),
    .delta_w_in(delta2), .load_init(load2), .w_init(w_init), .w_out(w_out2),
    .busy(busy2), .done(done2), .update_count(count2));

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] e3, e2, e1, e0);
    return {e3, e2, e1, e0};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic wait_done(input bit second);
    bit hit = 0;
    for (int k = 0; k < 20 && !hit; k++)
      if ((second ? done2 : done) === 1'b1) hit = 1;
      else tick();
    chk("done_within_bound", N*W'(hit), N*W'(1));
  endtask

  task automatic load(input logic [N*W-1:0] v);
    load_init = 1;
    w_init = v;
    tick();
    load_init = 0;
  endtask

  task automatic send(input logic [N*W-1:0] d);
    delta_w_in = d;
    delta_valid = 1;
    tick();
    delta_valid = 0;
  endtask

  initial begin
    vecs[0] = '{pk(MX-7, MN+8, 0, 0), pk(100, -100, 5, -5), pk(MX, MN, 5, -5)};
    vecs[1] = '{pk(7, -7, 123, 0), '0, pk(7, -7, 123, 0)};
    vecs[2] = '{pk(MX-1, MN+1, -1, 1), pk(1, -1, 1, -1), pk(MX, MN, 0, 0)};
    vecs[3] = '{pk(MN, MX, 100, -100), pk(-1, 1, -200, 200), pk(MN, MX, -100, 100)};
    vecs[4] = '{pk(MN, MX, 10, -10), pk(MX, MN, -10, 10), pk(-1, -1, 0, 0)};
    mid[0] = pk(4, 3, 2, 11);
    mid[1] = pk(4, 3, 4, 11);
    mid[2] = pk(4, 2, 4, 11);
    mid[3] = pk(3, 2, 4, 11);
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    repeat (2) tick();
    chk("ready_in_reset", N*W'(delta_ready), '0);
    chk("reset_w", w_out, '0);
    chk("reset_count", N*W'(update_count), '0);
    chk("reset_done", N*W'(done), '0);
    chk("reset_busy", N*W'(busy), '0);
    RST = 0;
    load_init = 1;
    w_init = pk(4, 3, 2, 1);
    #1;
    chk("ready_during_load", N*W'(delta_ready), '0);
    tick();
    load_init = 0;
    #1;
    chk("load_w", w_out, pk(4, 3, 2, 1));
    chk("ready_after_load", N*W'(delta_ready), N*W'(1));

    send(pk(-1, -1, 2, 10));
    chk("apply_start_w", w_out, pk(4, 3, 2, 1));
    chk("apply_busy", N*W'(busy), N*W'(1));
    for (int i = 0; i < N; i++) begin
      tick();
      chk($sformatf("elem_%0d_latency", i), w_out, mid[i]);
    end
    chk("done_pulse", N*W'(done), N*W'(1));
    chk("count_before_done_edge", N*W'(update_count), '0);
    tick();
    cnt_exp = 1;
    chk("done_one_cycle", N*W'(done), '0);
    chk("basic_count", N*W'(update_count), N*W'(cnt_exp));
    chk("ready_after_done", N*W'(delta_ready), N*W'(1));

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].init);
      send(vecs[v].delta);
      wait_done(0);
      tick();
      cnt_exp++;
      chk($sformatf("vec%0d_w", v), w_out, vecs[v].exp);
      chk($sformatf("vec%0d_count", v), N*W'(update_count), N*W'(cnt_exp));
    end

    load(pk(10, 20, 30, 40));
    delta_w_in = pk(1, 1, 1, 1);
    delta_valid = 1;
    tick();
    delta_w_in = pk(100, 100, 100, 100);
    for (int i = 0; i < N; i++) begin
      chk("ready_low_in_apply", N*W'(delta_ready), '0);
      tick();
    end
    chk("bp_done", N*W'(done), N*W'(1));
    chk("ready_low_in_done", N*W'(delta_ready), '0);
    tick();
    chk("bp_first_only", w_out, pk(11, 21, 31, 41));
    chk("bp_ready_back", N*W'(delta_ready), N*W'(1));
    tick();
    delta_valid = 0;
    wait_done(0);
    tick();
    cnt_exp += 2;
    chk("bp_second", w_out, pk(111, 121, 131, 141));
    chk("bp_count", N*W'(update_count), N*W'(cnt_exp));

    load_init = 1;
    w_init = pk(5, 5, 5, 5);
    delta_valid = 1;
    delta_w_in = pk(1, 2, 3, 4);
    #1;
    chk("prio_ready_low", N*W'(delta_ready), '0);
    tick();
    chk("prio_load_w", w_out, pk(5, 5, 5, 5));
    chk("prio_not_busy", N*W'(busy), '0);
    load_init = 0;
    #1;
    chk("prio_ready_high", N*W'(delta_ready), N*W'(1));
    tick();
    delta_valid = 0;
    chk("prio_accepted", N*W'(busy), N*W'(1));
    wait_done(0);
    tick();
    cnt_exp++;
    chk("prio_w", w_out, pk(6, 7, 8, 9));

    send(pk(1, 1, 1, 1));
    repeat (2) tick();
    chk("mid_apply_w", w_out, pk(6, 7, 9, 10));
    RST = 1;
    #1;
    chk("ready_low_rst", N*W'(delta_ready), '0);
    tick();
    chk("abort_w", w_out, '0);
    chk("abort_busy", N*W'(busy), '0);
    chk("abort_count", N*W'(update_count), '0);
    RST = 0;
    seen = 0;
    repeat (N + 2) begin
      if (done) seen = 1;
      tick();
    end
    chk("abort_no_done", N*W'(seen), '0);

    delta2 = pk(1, 1, 1, 1);
    valid2 = 1;
    for (int k = 0; k < 5; k++) begin
      wait_done(1);
      tick();
      chk($sformatf("wrap_count_%0d", k), N*W'(count2), N*W'(wrap_exp[k]));
    end
    valid2 = 0;
    chk("wrap_w", w_out2, pk(5, 5, 5, 5));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
